// File: rtl/alu_mem_seq_if.sv
// alu_mem_seq_if: request/response bundle between a requester and the ALU/memory sequencer
interface alu_mem_seq_if #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
);
   localparam int AW = $clog2(DEPTH);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic [2:0]       Op;
   logic [AW-1:0]    Address;
   logic [1:0]       MemOp;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH:0]   Y;
   logic [WIDTH:0]   MemOut;
   logic             err;
   modport master (
      output in_valid, A, B, Op, Address, MemOp, out_ready,
      input  in_ready, out_valid, Y, MemOut, err
   );
   modport slave (
      input  in_valid, A, B, Op, Address, MemOp, out_ready,
      output in_ready, out_valid, Y, MemOut, err
   );
endinterface

// File: rtl/alu_mem_seq.sv
// alu_mem_seq: handshaked ALU with shift-add multiply and a store/load/accumulate result memory
module alu_mem_seq #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input logic          clk,
   input logic          rst_n,
   alu_mem_seq_if.slave bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int RW = WIDTH + 1;
   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] BUSY = 2'd1;
   localparam logic [1:0] DONE = 2'd2;
   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_AND = 3'b010;
   localparam logic [2:0] OP_OR  = 3'b011;
   localparam logic [2:0] OP_XOR = 3'b100;
   localparam logic [2:0] OP_SHL = 3'b101;
   localparam logic [2:0] OP_MUL = 3'b110;
   localparam logic [2:0] OP_RSV = 3'b111;
   localparam logic [1:0] MEM_LD = 2'b10;

   logic [1:0]       state_q, state_d;
   logic [RW-1:0]    y_q, y_d;
   logic [RW-1:0]    memout_q, memout_d;
   logic             err_q, err_d;
   logic [RW-1:0]    acc_q, acc_d;
   logic [RW-1:0]    mcand_q, mcand_d;
   logic [WIDTH-1:0] mplier_q, mplier_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [AW-1:0]    addr_q, addr_d;
   logic [1:0]       memop_q, memop_d;
   logic [RW-1:0]    mem_q [DEPTH];

   logic [RW-1:0] a_x, b_x, alu_y, fin_y, wr_data;
   logic [AW-1:0] wr_addr;
   logic [1:0]    wr_op;
   logic          accept, is_mul, mul_done, done_entry, wr_en;

   // single-cycle ALU result from the operands presented at accept
   always_comb begin
      a_x   = {1'b0, bus.A};
      b_x   = {1'b0, bus.B};
      alu_y = bus.Op == OP_ADD ? a_x + b_x :
              bus.Op == OP_SUB ? a_x - b_x :
              bus.Op == OP_AND ? a_x & b_x :
              bus.Op == OP_OR  ? a_x | b_x :
              bus.Op == OP_XOR ? a_x ^ b_x :
              bus.Op == OP_SHL ? (int'(bus.B) >= RW ? '0 : a_x << bus.B) :
              '0;
   end

   // handshake decode, final result selection and memory write port
   always_comb begin
      accept     = bus.in_valid && state_q == IDLE;
      is_mul     = bus.Op == OP_MUL;
      mul_done   = state_q == BUSY && cnt_q == CW'(WIDTH - 1);
      fin_y      = state_q == BUSY ? acc_q + (mplier_q[0] ? mcand_q : '0) : alu_y;
      done_entry = (accept && !is_mul) || mul_done;
      wr_op      = state_q == IDLE ? bus.MemOp : memop_q;
      wr_addr    = state_q == IDLE ? bus.Address : addr_q;
      wr_en      = done_entry && wr_op[0] && !(state_q == IDLE && bus.Op == OP_RSV);
      wr_data    = wr_op[1] ? mem_q[wr_addr] + fin_y : fin_y;
   end

   // next-state for the sequencer, multiplier datapath and held outputs
   always_comb begin
      state_d  = accept ? (is_mul ? BUSY : DONE) :
                 mul_done ? DONE :
                 (state_q == DONE && bus.out_ready) ? IDLE : state_q;
      acc_d    = accept ? '0 : state_q == BUSY ? fin_y : acc_q;
      mcand_d  = accept ? a_x : state_q == BUSY ? mcand_q << 1 : mcand_q;
      mplier_d = accept ? bus.B : state_q == BUSY ? mplier_q >> 1 : mplier_q;
      cnt_d    = accept ? '0 : state_q == BUSY ? cnt_q + 1'b1 : cnt_q;
      addr_d   = accept ? bus.Address : addr_q;
      memop_d  = accept ? bus.MemOp : memop_q;
      y_d      = done_entry ? fin_y : y_q;
      err_d    = accept ? bus.Op == OP_RSV : err_q;
      memout_d = accept ? (bus.MemOp == MEM_LD ? mem_q[bus.Address] : '0) : memout_q;
   end

   // control and datapath registers, cleared by reset (abandons any multiply)
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         y_q      <= '0;
         memout_q <= '0;
         err_q    <= 1'b0;
         acc_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         cnt_q    <= '0;
         addr_q   <= '0;
         memop_q  <= '0;
      end else begin
         state_q  <= state_d;
         y_q      <= y_d;
         memout_q <= memout_d;
         err_q    <= err_d;
         acc_q    <= acc_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         cnt_q    <= cnt_d;
         addr_q   <= addr_d;
         memop_q  <= memop_d;
      end
   end

   // result memory: written on the edge that enters DONE, fully cleared by reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else if (wr_en) begin
         mem_q[wr_addr] <= wr_data;
      end
   end

   assign bus.in_ready  = state_q == IDLE;
   assign bus.out_valid = state_q == DONE;
   assign bus.Y         = y_q;
   assign bus.MemOut    = memout_q;
   assign bus.err       = err_q;
endmodule
